bram_sm_seq: RTL and testbench
==============================

// Module: bram_sm_seq
// PURPOSE
//  Parametrised sequencer between a single-port row BRAM and the softmax core.
//  Streams i_num_rows rows from RD_BASE into softmax and writes each result row back from WR_BASE.
//  Uses no fixed wait count: writes are driven by softmax valid, and BRAM port contention is arbitrated.
//  Adds runtime row count, start/busy/done control, drain timeout and an error flag.
// PARAMETERS
//  DATA_W      1024  row width in bits (softmax in/out and BRAM data)
//  ADDR_W      5     BRAM address width
//  N_ROWS      12    maximum rows per job; i_num_rows is clamped to this value
//  RD_BASE     0     first BRAM address read
//  WR_BASE     12    first BRAM address written
//  BRAM_RD_LAT 1     BRAM read latency in cycles, 1..4
//  TIMEOUT     255   max idle cycles in DRAIN before abort
// PORTS
//  i_clk            in   1       clock
//  i_rst            in   1       async reset, active-high
//  i_start          in   1       job start; sampled only in IDLE
//  i_num_rows       in   ADDR_W  rows in this job; 0 = empty job
//  i_length_mode    in   2       softmax length mode, latched at start
//  o_busy           out  1       high from the cycle after start until DONE
//  o_done           out  1       one-cycle pulse at job end
//  o_err            out  1       sticky: timeout or unexpected i_sm_valid
//  o_sm_length_mode out  2       latched length mode
//  o_sm_valid       out  1       o_sm_in_x_flat holds a valid row
//  o_sm_in_x_flat   out  DATA_W  equals i_bram_rdata (combinational)
//  i_sm_valid       in   1       softmax result valid; cannot be stalled
//  i_sm_prob_flat   in   DATA_W  softmax result row
//  o_bram_addr      out  ADDR_W  BRAM address
//  o_bram_en        out  1       BRAM enable
//  o_bram_we        out  1       BRAM write enable
//  o_bram_wdata     out  DATA_W  equals i_sm_prob_flat (combinational)
//  i_bram_rdata     in   DATA_W  BRAM read data
// BEHAVIOUR
//  Reset values (async): state=IDLE; o_bram_addr=0; o_bram_en, o_bram_we, o_sm_valid, o_busy, o_done, o_err=0;
//   o_sm_length_mode=2'd2; all counters and the valid pipeline cleared. A reset mid-job aborts the job with no done pulse.
//  All outputs except o_sm_in_x_flat and o_bram_wdata are registered.
//  Default each cycle: en=we=done=0.
//  States:
//   IDLE: on i_start, latch mode and nr=min(i_num_rows,N_ROWS), clear rd_cnt, wr_cnt and o_err.
//    If nr==0 go to DONE; otherwise go to RUN.
//   RUN: issue one read per cycle: en=1, we=0, addr=RD_BASE+rd_cnt, rd_cnt++.
//    Go to DRAIN in the same cycle that the read with rd_cnt==nr-1 is issued.
//   DRAIN: no reads issued; wait until wr_cnt==nr, then go to DONE.
//   DONE: o_done=1 for one cycle, o_busy=0, go to IDLE.
//  Write handling (RUN or DRAIN) when i_sm_valid=1:
//   Next cycle: en=1, we=1, addr=WR_BASE+wr_cnt, wr_cnt++. wdata is captured by the BRAM on that edge.
//   o_bram_wdata is combinational, so softmax must hold its output for 1 cycle; this is the core's contract.
//  Port conflict: a pending write wins. The RUN read is stalled for that cycle (rd_cnt held) and retried next cycle.
//  o_sm_valid is asserted exactly BRAM_RD_LAT cycles after each read issue, via a shift register.
//   Stalled reads generate no o_sm_valid.
//  Rows are written in the same order as they were read; softmax is in-order.
//  o_err is set when:
//   - i_sm_valid arrives in IDLE or DONE, or when wr_cnt==nr (the write is dropped);
//   - DRAIN sees TIMEOUT consecutive cycles without i_sm_valid. The state then goes to DONE and o_done pulses.
//  An i_start seen while not in IDLE is ignored.
//  Address arithmetic is ADDR_W bits wide and wraps modulo 2^ADDR_W. Keeping ranges inside the BRAM is the integrator's job.
//  Counter width is ADDR_W+1 bits.
// TESTING
//  T1: nr=12, softmax model latency 52, RD_LAT=1 -> reads at addr 0..11 on 12 consecutive cycles;
//      o_sm_valid 12 cycles; writes at addr 12..23 in order; done pulse; err=0.
//  T2: i_sm_valid arrives in the same cycle a read would issue (model latency 3, nr=8)
//      -> write wins, read stalled one cycle, all 8 reads and 8 writes occur with no duplicates.
//  T3: i_num_rows=0 -> no BRAM enable; o_done 1 cycle after start; busy never high beyond that.
//  T4: nr=4, model drops the last result -> after 255 idle cycles in DRAIN: o_err=1, o_done pulses, wr_cnt=3.
//  T5: i_sm_valid pulse while IDLE -> o_err=1 and no BRAM write; the next i_start clears o_err.
//  T6: assert i_rst in RUN at rd_cnt=5 -> all outputs at reset values immediately;
//      a fresh start runs the full job correctly.

Source files
------------

// File: rtl/bram_sm_seq.sv
// bram_sm_seq: streams rows from a single-port BRAM through softmax and writes results back,
// arbitrating the port between result writes (priority) and row reads.
module bram_sm_seq #(
    parameter int DATA_W      = 1024,
    parameter int ADDR_W      = 5,
    parameter int N_ROWS      = 12,
    parameter int RD_BASE     = 0,
    parameter int WR_BASE     = 12,
    parameter int BRAM_RD_LAT = 1,
    parameter int TIMEOUT     = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_num_rows,
    input  logic [1:0]        i_length_mode,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [1:0]        o_sm_length_mode,
    output logic              o_sm_valid,
    output logic [DATA_W-1:0] o_sm_in_x_flat,
    input  logic              i_sm_valid,
    input  logic [DATA_W-1:0] i_sm_prob_flat,
    output logic [ADDR_W-1:0] o_bram_addr,
    output logic              o_bram_en,
    output logic              o_bram_we,
    output logic [DATA_W-1:0] o_bram_wdata,
    input  logic [DATA_W-1:0] i_bram_rdata
);
    localparam int CW = ADDR_W + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state, state_n;
    logic [CW-1:0]      nr, nr_in, rd_cnt, wr_cnt;
    logic [TW-1:0]      idle;
    logic [BRAM_RD_LAT:0] pipe;
    logic               start_go, wr_go, rd_go, last_rd, tmo, wr_full;

    assign o_sm_in_x_flat = i_bram_rdata;
    assign o_bram_wdata   = i_sm_prob_flat;
    assign o_sm_valid     = pipe[BRAM_RD_LAT];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state            <= IDLE;
            nr               <= '0;
            rd_cnt           <= '0;
            wr_cnt           <= '0;
            idle             <= '0;
            pipe             <= '0;
            o_bram_addr      <= '0;
            o_bram_en        <= 1'b0;
            o_bram_we        <= 1'b0;
            o_busy           <= 1'b0;
            o_done           <= 1'b0;
            o_err            <= 1'b0;
            o_sm_length_mode <= 2'd2;
        end else begin
            state     <= state_n;
            o_bram_en <= wr_go || rd_go;
            o_bram_we <= wr_go;
            if (wr_go)
                o_bram_addr <= ADDR_W'(WR_BASE) + wr_cnt[ADDR_W-1:0];
            else if (rd_go)
                o_bram_addr <= ADDR_W'(RD_BASE) + rd_cnt[ADDR_W-1:0];
            rd_cnt <= start_go ? '0 : rd_cnt + CW'(rd_go);
            wr_cnt <= start_go ? '0 : wr_cnt + CW'(wr_go);
            if (start_go) begin
                nr               <= nr_in;
                o_sm_length_mode <= i_length_mode;
            end
            // a dropped result (no room or no job) is flagged; a new start clears the flag
            o_err  <= start_go ? 1'b0 : (o_err || (i_sm_valid && !wr_go) || tmo);
            idle   <= (state == DRAIN && !i_sm_valid) ? idle + TW'(1) : '0;
            pipe   <= {pipe[BRAM_RD_LAT-1:0], rd_go};
            o_busy <= state_n == RUN || state_n == DRAIN;
            o_done <= state_n == DONE;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = i_start ? (nr_in == '0 ? DONE : RUN) : IDLE;
            RUN:     state_n = (rd_go && last_rd) ? DRAIN : RUN;
            DRAIN:   state_n = (wr_full || tmo) ? DONE : DRAIN;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        nr_in    = ({1'b0, i_num_rows} > CW'(N_ROWS)) ? CW'(N_ROWS) : {1'b0, i_num_rows};
        start_go = state == IDLE && i_start;
        wr_full  = wr_cnt == nr;
        wr_go    = i_sm_valid && (state == RUN || state == DRAIN) && !wr_full;
        rd_go    = state == RUN && !wr_go;
        last_rd  = rd_cnt == nr - CW'(1);
        tmo      = state == DRAIN && !wr_full && !i_sm_valid && idle == TW'(TIMEOUT - 1);
    end
endmodule

// File: tb/tb_bram_sm_seq.sv
// tb_bram_sm_seq: scoreboard bench with a BRAM model and an in-order, fixed-latency softmax model.
module tb_bram_sm_seq;
    localparam int DW = 128;

    typedef struct {
        int              t;
        logic [DW-1:0]   d;
    } ent_t;

    logic          i_clk = 0;
    logic          i_rst = 1;
    logic          i_start = 0;
    logic [4:0]    i_num_rows = 0;
    logic [1:0]    i_length_mode = 0;
    logic          o_busy, o_done, o_err, o_sm_valid, o_bram_en, o_bram_we;
    logic [1:0]    o_sm_length_mode;
    logic [DW-1:0] o_sm_in_x_flat, o_bram_wdata;
    logic          i_sm_valid = 0;
    logic [DW-1:0] i_sm_prob_flat = '0;
    logic [DW-1:0] i_bram_rdata = '0;
    logic [4:0]    o_bram_addr;

    logic [DW-1:0] wmem [32];
    int cyc = 0;
    int n_chk = 0, n_pass = 0;
    int m_lat = 52, m_nr = 0, stray_cnt = 0;
    bit m_drop = 0;

    int    exp_rd[$];
    logic [DW-1:0] exp_x[$];
    logic [DW-1:0] exp_wd[$];
    int    exp_wa[$];

    bram_sm_seq #(.DATA_W(DW)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_num_rows(i_num_rows),
        .i_length_mode(i_length_mode), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
        .o_sm_length_mode(o_sm_length_mode), .o_sm_valid(o_sm_valid), .o_sm_in_x_flat(o_sm_in_x_flat),
        .i_sm_valid(i_sm_valid), .i_sm_prob_flat(i_sm_prob_flat), .o_bram_addr(o_bram_addr),
        .o_bram_en(o_bram_en), .o_bram_we(o_bram_we), .o_bram_wdata(o_bram_wdata),
        .i_bram_rdata(i_bram_rdata)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] row(input int a);
        logic [31:0] w;
        w = 32'(a + 1) * 32'h9E3779B9;
        return {w, ~w, w ^ 32'h5A5A5A5A, w + 32'd7};
    endfunction

    always @(posedge i_clk) begin
        if (o_bram_en && o_bram_we) wmem[o_bram_addr] <= o_bram_wdata;
        if (o_bram_en && !o_bram_we) i_bram_rdata <= row(int'(o_bram_addr));
    end

    // softmax model: result = ~row, issued m_lat cycles after the row, at most every other cycle
    ent_t mq[$];
    int seen = 0, last_emit = -10, stray_done = 0;
    always @(negedge i_clk) begin
        i_sm_valid = 0;
        if (i_rst || o_done) begin
            mq.delete();
            seen = 0;
        end else begin
            if (o_sm_valid) begin
                if (!(m_drop && seen == m_nr - 1)) mq.push_back('{cyc + m_lat, ~o_sm_in_x_flat});
                seen++;
            end
            if (stray_cnt != stray_done) begin
                stray_done = stray_cnt;
                i_sm_valid = 1;
            end else if (mq.size() > 0 && mq[0].t <= cyc && cyc >= last_emit + 2) begin
                i_sm_valid     = 1;
                i_sm_prob_flat = mq[0].d;
                void'(mq.pop_front());
                last_emit = cyc;
            end
        end
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic run_job(input int nreq, input int lat, input bit drop, input logic [1:0] mode,
                           output int span, output int gap);
        int nr, nwr, rd_n, wr_n, first_rd, last_rd, wr_last, done_c, start_c;
        bit fin;
        nr  = nreq > 12 ? 12 : nreq;
        nwr = drop ? nr - 1 : nr;
        m_lat = lat; m_drop = drop; m_nr = nr;
        exp_rd.delete(); exp_x.delete(); exp_wa.delete(); exp_wd.delete();
        for (int k = 0; k < nr; k++) begin
            exp_rd.push_back(k);
            exp_x.push_back(row(k));
        end
        for (int k = 0; k < nwr; k++) begin
            exp_wa.push_back(12 + k);
            exp_wd.push_back(~row(k));
        end
        i_num_rows = 5'(nreq); i_length_mode = mode; i_start = 1;
        @(negedge i_clk);
        i_start = 0;
        start_c = cyc;
        check("busy_start", o_busy, nr != 0);
        check("err_clear", o_err, 0);
        check("mode_latch", o_sm_length_mode, mode);
        rd_n = 0; wr_n = 0; first_rd = -1; last_rd = -1; wr_last = -1; done_c = -1; fin = 0;
        for (int c = 0; c < 2000 && !fin; c++) begin
            if (o_bram_en && o_bram_we) begin
                wr_n++; wr_last = cyc;
                if (exp_wa.size() == 0) check("wr_extra", 1, 0);
                else begin
                    check("wr_addr", o_bram_addr, exp_wa.pop_front());
                    check("wr_data", o_bram_wdata, exp_wd.pop_front());
                end
            end else if (o_bram_en) begin
                rd_n++; last_rd = cyc;
                if (first_rd < 0) first_rd = cyc;
                if (exp_rd.size() == 0) check("rd_extra", 1, 0);
                else check("rd_addr", o_bram_addr, exp_rd.pop_front());
            end
            if (o_sm_valid) begin
                if (exp_x.size() == 0) check("smv_extra", 1, 0);
                else check("sm_x", o_sm_in_x_flat, exp_x.pop_front());
            end
            if (o_done) begin
                fin = 1; done_c = cyc;
            end else @(negedge i_clk);
        end
        check("done_seen", fin, 1);
        if (nr == 0) begin
            check("empty_done_lat", done_c - start_c, 0);
            check("empty_no_en", rd_n + wr_n, 0);
        end
        check("busy_at_done", o_busy, 0);
        check("err_at_done", o_err, drop);
        check("rd_count", rd_n, nr);
        check("wr_count", wr_n, nwr);
        check("leftover", exp_rd.size() + exp_x.size() + exp_wa.size(), 0);
        @(negedge i_clk);
        check("done_one_cycle", o_done, 0);
        check("busy_idle", o_busy, 0);
        span = last_rd - first_rd;
        gap  = done_c - wr_last;
    endtask

    initial begin
        int span, gap, rd_seen;
        repeat (2) @(negedge i_clk);
        check("rst_en", o_bram_en, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_err", o_err, 0);
        check("rst_addr", o_bram_addr, 0);
        check("rst_mode", o_sm_length_mode, 2);
        i_rst = 0;
        @(negedge i_clk);

        run_job(0, 52, 0, 2'd3, span, gap);
        run_job(12, 52, 0, 2'd1, span, gap);
        check("t1_read_span", span, 11);
        for (int k = 0; k < 12; k++) check("t1_wmem", wmem[12 + k], ~row(k));
        run_job(8, 3, 0, 2'd0, span, gap);
        check("t2_stalled", span > 7, 1);
        run_job(4, 52, 1, 2'd2, span, gap);
        check("t4_timeout_gap", gap, 255);

        stray_cnt++;
        for (int c = 0; c < 4; c++) begin
            @(negedge i_clk);
            check("stray_no_en", o_bram_en, 0);
        end
        check("stray_err", o_err, 1);
        run_job(3, 5, 0, 2'd1, span, gap);

        m_lat = 52; m_drop = 0; m_nr = 12;
        i_num_rows = 5'd12; i_length_mode = 2'd1; i_start = 1;
        @(negedge i_clk);
        i_start = 0;
        rd_seen = 0;
        for (int c = 0; c < 50 && rd_seen < 5; c++) begin
            if (o_bram_en && !o_bram_we) begin
                check("t6_rd_addr", o_bram_addr, rd_seen);
                rd_seen++;
            end
            if (rd_seen < 5) @(negedge i_clk);
        end
        check("t6_reads", rd_seen, 5);
        check("t6_busy_before", o_busy, 1);
        i_rst = 1;
        #1;
        check("t6_en", o_bram_en, 0);
        check("t6_we", o_bram_we, 0);
        check("t6_smv", o_sm_valid, 0);
        check("t6_busy", o_busy, 0);
        check("t6_done", o_done, 0);
        check("t6_addr", o_bram_addr, 0);
        check("t6_mode", o_sm_length_mode, 2);
        repeat (2) @(negedge i_clk);
        check("t6_no_done", o_done, 0);
        i_rst = 0;
        @(negedge i_clk);
        run_job(31, 52, 0, 2'd1, span, gap);
        check("t6_span", span, 11);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
